seq_divider_unit: RTL and testbench
===================================

SEQ_DIVIDER_UNIT -- requirements
Module: seq_divider_unit

Interface
REQ-001 SHALL provide parameter DIVIDEND_W, default 8, dividend and quotient width.
REQ-002 SHALL provide parameter DIVISOR_W, default 4, divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, unit accepts operands.
REQ-007 SHALL have port dividend, input, DIVIDEND_W, unsigned dividend.
REQ-008 SHALL have port divisor, input, DIVISOR_W, unsigned divisor.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port quotient, output, DIVIDEND_W, unsigned quotient.
REQ-012 SHALL have port remainder, output, DIVISOR_W, unsigned remainder.
REQ-013 SHALL have port div_by_zero, output, 1, divisor was zero for the current result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL latch dividend and divisor, and clear the partial remainder (DIVISOR_W+1 bits) and the iteration counter, on the edge where in_valid&in_ready.
REQ-017 SHALL, on acceptance with divisor≠0, enter RUN; with divisor=0, enter DONE directly with quotient all-ones, remainder 0, div_by_zero=1.
REQ-018 SHALL, in RUN, resolve one quotient bit per cycle, MSB first, by restoring division: shift {partial remainder, next dividend bit}; subtract zero-extended divisor; when there is no borrow, keep the difference and set the bit to 1, else keep the shifted value and set the bit to 0.
REQ-019 SHALL spend exactly DIVIDEND_W cycles in RUN and enter DONE on the edge completing the last bit, so out_valid rises DIVIDEND_W+1 edges after the acceptance edge (9 at defaults).
REQ-020 SHALL hold quotient, remainder and div_by_zero stable while out_valid=1 and out_ready=0.
REQ-021 SHALL return to IDLE on the edge where out_valid&out_ready; no new operands are accepted on that same edge.
REQ-022 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-023 SHALL guarantee remainder<divisor and quotient*divisor+remainder=dividend for every divisor≠0.
REQ-024 SHALL clear div_by_zero on every new acceptance with a nonzero divisor.
REQ-025 SHALL hold quotient/remainder at their last values in IDLE and RUN; these values are don't-care while out_valid=0.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and partial remainder.
REQ-027 SHALL apply reset in any state, including mid-RUN and in DONE with out_valid pending; the in-flight result is discarded and not presented.
REQ-028 SHALL accept operands on the first edge after rst_n returns high.

Structure
REQ-029 SHALL place default widths and the FSM state enumeration in the shared arithmetic package.
REQ-030 SHALL instantiate one combinational sub-module, div_step, that takes the partial remainder, the incoming dividend bit and the divisor, and returns the next partial remainder and the quotient bit.
REQ-031 SHALL contain no combinational path from in_valid or out_ready to any output.

Verification
REQ-032 SHALL verify 200/7 -> quotient=28, remainder=4, div_by_zero=0, with out_valid exactly 9 edges after acceptance.
REQ-033 SHALL verify 255/1 -> quotient=255, remainder=0; and 13/15 -> quotient=0, remainder=13.
REQ-034 SHALL verify 100/0 -> out_valid one edge after acceptance, quotient=255, remainder=0, div_by_zero=1; then 100/3 -> quotient=33, remainder=1, div_by_zero=0.
REQ-035 SHALL verify 200/7 with out_ready held low 3 cycles -> outputs stable and in_ready=0 throughout; a new in_valid during DONE is ignored; the pair is accepted only after the out handshake.
REQ-036 SHALL verify rst_n=0 at RUN cycle 4 of 200/7 -> next cycle IDLE with in_ready=1 and out_valid=0; then 9/2 -> quotient=4, remainder=1.
REQ-037 SHALL verify an exhaustive sweep of all 256×16 operand pairs against a reference model, including the REQ-023 invariant.

Source files
------------

// File: rtl/seq_divider_unit_pkg.sv
// Shared definitions for the sequential restoring divider: default operand widths
// and the controller state encoding.
package seq_divider_unit_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : seq_divider_unit_pkg

// File: rtl/seq_divider_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference when it does not borrow.
module seq_divider_unit_div_step
    import seq_divider_unit_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   prem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   prem_o,
    output logic                 qbit_o
);

    logic [DIVISOR_W:0] shifted;
    logic               no_borrow;

    // A set top bit in prem_i means the shifted value already exceeds any divisor,
    // so the compare only needs DIVISOR_W+1 bits.
    assign shifted   = {prem_i[DIVISOR_W-1:0], bit_i};
    assign no_borrow = prem_i[DIVISOR_W] | (shifted >= {1'b0, divisor_i});
    assign prem_o    = no_borrow ? (shifted - {1'b0, divisor_i}) : shifted;
    assign qbit_o    = no_borrow;

endmodule : seq_divider_unit_div_step

// File: rtl/seq_divider_unit.sv
// Sequential unsigned divider: accepts operands in IDLE, resolves one quotient bit
// per cycle in RUN, and holds the result in DONE until the consumer takes it.
module seq_divider_unit
    import seq_divider_unit_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W    = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    div_state_e            state_q, state_d;
    logic [DIVIDEND_W-1:0] acc_q,   acc_d;   // dividend shifts out the top, quotient shifts in below
    logic [DIVISOR_W-1:0]  dsr_q,   dsr_d;
    logic [DIVISOR_W:0]    prem_q,  prem_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DIVIDEND_W-1:0] quot_q,  quot_d;
    logic [DIVISOR_W-1:0]  rem_q,   rem_d;
    logic                  dbz_q,   dbz_d;

    logic [DIVISOR_W:0]    step_prem;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] acc_shift;

    seq_divider_unit_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) div_step (
        .prem_i    (prem_q),
        .bit_i     (acc_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .prem_o    (step_prem),
        .qbit_o    (step_qbit)
    );

    assign acc_shift = {acc_q[DIVIDEND_W-2:0], step_qbit};

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d  = dividend;
                    dsr_d  = divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                acc_d  = acc_shift;
                prem_d = step_prem;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    quot_d  = acc_shift;
                    rem_d   = step_prem[DIVISOR_W-1:0];
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule : seq_divider_unit

// File: tb/tb_seq_divider_unit.sv
// Self-checking bench for seq_divider_unit: directed corner cases, backpressure,
// reset recovery and a full operand sweep against an arithmetic reference model.
module tb_seq_divider_unit;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    seq_divider_unit #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    function automatic void model(input int a, input int b, output int q, output int r, output bit z);
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = 0;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int a, input int b);
        int g;
        g = 0;
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_ready_timeout: in_ready=%b, required 1", in_ready);
        end
        dividend = DW'(a);
        divisor  = VW'(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges from acceptance (the acceptance edge itself is edge 1).
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, div_by_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b dbz=%b q=%0d r=%0d, required rdy=1 vld=0 dbz=0 q=0 r=0",
                     in_ready, out_valid, div_by_zero, quotient, remainder);
        end
        // Operands offered together with reset release must be taken on the very next edge.
        rst_n    = 1'b1;
        dividend = 8'd13;
        divisor  = 4'd15;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL accept_after_reset: in_ready=%b, required 0", in_ready);
        end
        wait_result(lat);
        checks++;
        if (quotient !== 8'd0 || remainder !== 4'd13) begin
            fails++;
            $display("FAIL post_reset_13_15: q=%0d r=%0d, required q=0 r=13", quotient, remainder);
        end
        consume();
    endtask

    task automatic test_directed();
        int ta[5]  = '{200, 255, 13, 100, 100};
        int tb[5]  = '{7, 1, 15, 0, 3};
        int tq[5]  = '{28, 255, 0, 255, 33};
        int tr[5]  = '{4, 0, 13, 0, 1};
        int tz[5]  = '{0, 0, 0, 1, 0};
        int tl[5]  = '{9, 9, 9, 1, 9};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i]);
            wait_result(lat);
            checks++;
            if (lat != tl[i]) begin
                fails++;
                $display("FAIL latency_%0d_%0d: %0d edges, required %0d", ta[i], tb[i], lat, tl[i]);
            end
            checks++;
            if (int'(quotient) != tq[i] || int'(remainder) != tr[i] || int'(div_by_zero) != tz[i]) begin
                fails++;
                $display("FAIL result_%0d_%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%0d",
                         ta[i], tb[i], quotient, remainder, div_by_zero, tq[i], tr[i], tz[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(200, 7);
        wait_result(lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd28 ||
                remainder !== 4'd4 || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold_%0d: vld=%b rdy=%b q=%0d r=%0d dbz=%b, required vld=1 rdy=0 q=28 r=4 dbz=0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
            // New operands offered while the result is still pending must not be taken.
            dividend = 8'd50;
            divisor  = 4'd5;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL handshake_edge_no_accept: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL accept_after_handshake: in_ready=%b, required 0", in_ready);
        end
        wait_result(lat);
        checks++;
        if (quotient !== 8'd10 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL deferred_50_5: q=%0d r=%0d dbz=%b, required q=10 r=0 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int  lat;
        bit  leaked;
        issue(200, 7);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, div_by_zero, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
            fails++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b dbz=%b q=%0d r=%0d, required rdy=1 vld=0 dbz=0 q=0 r=0",
                     in_ready, out_valid, div_by_zero, quotient, remainder);
        end
        rst_n  = 1'b1;
        leaked = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            fails++;
            $display("FAIL discarded_result_shown: out_valid rose after reset, required 0");
        end
        issue(9, 2);
        wait_result(lat);
        checks++;
        if (quotient !== 8'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_9_2: q=%0d r=%0d dbz=%b, required q=4 r=1 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        consume();
        // Reset while a result is pending in DONE.
        issue(200, 7);
        wait_result(lat);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd0) begin
            fails++;
            $display("FAIL reset_in_done: vld=%b rdy=%b q=%0d, required vld=0 rdy=1 q=0",
                     out_valid, in_ready, quotient);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        int lat, stall, eq, er, gq, gr;
        bit ez;
        logic [DW-1:0] hq;
        logic [VW-1:0] hr;
        logic          hz;
        for (int a = 0; a < (1 << DW); a++) begin
            for (int b = 0; b < (1 << VW); b++) begin
                issue(a, b);
                wait_result(lat);
                checks++;
                if (lat != ((b == 0) ? 1 : DW + 1)) begin
                    fails++;
                    $display("FAIL sweep_latency %0d/%0d: %0d edges, required %0d",
                             a, b, lat, (b == 0) ? 1 : DW + 1);
                end
                hq = quotient;
                hr = remainder;
                hz = div_by_zero;
                stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                repeat (stall) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                checks++;
                if (out_valid !== 1'b1 || quotient !== hq || remainder !== hr || div_by_zero !== hz) begin
                    fails++;
                    $display("FAIL sweep_hold %0d/%0d: vld=%b q=%0d r=%0d, required vld=1 q=%0d r=%0d",
                             a, b, out_valid, quotient, remainder, hq, hr);
                end
                model(a, b, eq, er, ez);
                gq = int'(quotient);
                gr = int'(remainder);
                checks++;
                if (gq != eq || gr != er || div_by_zero !== ez) begin
                    fails++;
                    $display("FAIL sweep %0d/%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                             a, b, gq, gr, div_by_zero, eq, er, ez);
                end
                if (b != 0) begin
                    checks++;
                    if (gr >= b || gq * b + gr != a) begin
                        fails++;
                        $display("FAIL sweep_invariant %0d/%0d: q=%0d r=%0d", a, b, gq, gr);
                    end
                end
                consume();
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_seq_divider_unit
